// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Issue/result bundle between the datapath controller and alu_seq.
// Revision : 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             z;

    modport master (
        output start, op, a, b,
        input  busy, done, s, z
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, s, z
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU with single-cycle ops plus iterative unsigned
//            multiply/divide/remainder behind a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);
    localparam int SHW    = $clog2(WIDTH);
    localparam int c_HALF = WIDTH / 2;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;

    localparam logic [SHW-1:0] c_LAST = SHW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_sel;
    logic [WIDTH-1:0]   r_s;
    logic               r_z;
    logic               r_done;

    logic               w_busy;
    logic               w_accept;
    logic               w_last;
    logic               w_single;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_imm_res;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_dsub;
    logic               w_dge;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_step_nxt;
    logic [WIDTH-1:0]   w_iter_res;

    // Iterative ops are op[4]=1 with op[3:2]=00; everything else completes at once.
    assign w_single = ~bus.op[4] | (bus.op[3:2] != 2'b00);
    assign w_accept = bus.start & (r_state == c_S_IDLE);
    assign w_sh     = bus.a[SHW-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept && !w_single) begin
                    w_state_nxt = bus.op[1] ? c_S_DIV : c_S_MUL;
                end
            end
            c_S_MUL, c_S_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_last = 1'b0;
        case (r_state)
            c_S_MUL, c_S_DIV: begin
                w_busy = 1'b1;
                w_last = (r_cnt == c_LAST);
            end
            default: begin
                w_busy = 1'b0;
                w_last = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (bus.op[1:0])
            2'b00: w_alu = bus.op[2] ? (bus.a - bus.b) : (bus.a + bus.b);
            2'b01: w_alu = bus.op[2] ? (bus.a | bus.b) : (bus.a & bus.b);
            2'b10: w_alu = bus.op[2] ? {bus.b[c_HALF-1:0], {c_HALF{1'b0}}}
                                     : (bus.a ^ bus.b);
            default: begin
                case (bus.op[3:2])
                    2'b00:   w_alu = bus.b << w_sh;
                    2'b01:   w_alu = bus.b >> w_sh;
                    2'b11:   w_alu = $unsigned($signed(bus.b) >>> w_sh);
                    default: w_alu = '0;
                endcase
            end
        endcase
    end

    assign w_imm_res = bus.op[4] ? '0 : w_alu;

    // ------------------------------------------------------------------
    // Iteration step. r_prod holds {acc, multiplier} for MUL and
    // {remainder, dividend/quotient} for DIV, so r_sel picks the upper
    // half for both MULHI and REMU.
    // ------------------------------------------------------------------
    assign w_madd    = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_madd, r_prod[WIDTH-1:1]};

    // Compare (not sign of the difference) so a zero divisor keeps shifting a into the remainder.
    assign w_rsh     = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_dsub    = w_rsh - {1'b0, r_opnd};
    assign w_dge     = (w_rsh >= {1'b0, r_opnd});
    assign w_div_nxt = w_dge ? {w_dsub[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1}
                             : {w_rsh[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b0};

    assign w_step_nxt = (r_state == c_S_DIV) ? w_div_nxt : w_mul_nxt;
    assign w_iter_res = r_sel ? w_step_nxt[2*WIDTH-1:WIDTH] : w_step_nxt[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_opnd <= '0;
            r_prod <= '0;
            r_sel  <= 1'b0;
            r_s    <= '0;
            r_z    <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt  <= '0;
                r_sel  <= bus.op[0];
                r_opnd <= bus.op[1] ? bus.b : bus.a;
                r_prod <= {{WIDTH{1'b0}}, (bus.op[1] ? bus.a : bus.b)};
                if (w_single) begin
                    r_s    <= w_imm_res;
                    r_z    <= (w_imm_res == '0);
                    r_done <= 1'b1;
                end
            end else if (w_busy) begin
                r_prod <= w_step_nxt;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    r_s    <= w_iter_res;
                    r_z    <= (w_iter_res == '0);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.z    = r_z;
endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered ALU for the multi-cycle datapath. It supports the existing 4-bit ALU operation set: ADD, SUB, AND, OR, XOR, LUI, SLL, SRL and SRA. It adds iterative unsigned multiply, divide and remainder. Operations are issued with a start/busy/done handshake. Result and zero flag are registered and held until the next completion.

Parameters:
WIDTH, 32, datapath width in bits; must be even and at least 8.
SHW, $clog2(WIDTH), derived local parameter, not overridable; width of the shift-amount field.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request to issue; accepted only when busy=0
op  input  5  operation select; see Behaviour
a  input  WIDTH  operand A; shift amount for shift ops
b  input  WIDTH  operand B; value shifted for shift ops
busy  output  1  high while an iterative op is in progress
done  output  1  one-cycle pulse when s and z are updated
s  output  WIDTH  registered result
z  output  1  registered flag, 1 when s == 0

Behaviour:
- Reset (synchronous, on any cycle including mid-operation):
  - s=0, z=1, busy=0, done=0.
  - State returns to IDLE; any in-flight op is discarded with no done pulse.
- States: IDLE, MUL, DIV.
- Acceptance: an op is accepted at edge T when start=1 and busy=0. a, b and op are latched at T; later changes are ignored.
- start while busy=1 is ignored, with no queueing.
- Single-cycle ops (op[4]=0). s, z and done=1 appear after edge T; busy stays 0. op[3:0] encoding (x = don't care):
  - x000 ADD: s = a+b, modulo 2^WIDTH.
  - x100 SUB: s = a-b, modulo 2^WIDTH.
  - x001 AND.
  - x101 OR.
  - x010 XOR.
  - x110 LUI: s = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0011 SLL: s = b << a[SHW-1:0].
  - 0111 SRL: logical right shift of b by a[SHW-1:0].
  - 1111 SRA: arithmetic right shift of b by a[SHW-1:0].
  - Any other op[3:0]: s = 0.
  - Upper bits of a above SHW are ignored for shifts.
- Iterative ops (op[4]=1):
  - 10000 MULLO: low WIDTH bits of a*b, unsigned.
  - 10001 MULHI: high WIDTH bits of a*b, unsigned.
  - 10010 DIVU: quotient of a/b.
  - 10011 REMU: remainder of a/b.
  - 101xx and 11xxx: single-cycle completion, s = 0.
  - MUL uses a shift-add over a 2*WIDTH product register; DIV uses restoring shift-subtract, one bit per cycle.
  - busy=1 on cycles T+1 .. T+WIDTH, with exactly WIDTH iteration cycles.
  - At the edge ending cycle T+WIDTH: s and z are written, busy=0, and done=1 for cycle T+WIDTH+1.
  - A new start during cycle T+WIDTH+1 is accepted, giving back-to-back issue.
- Divide by zero (b=0): DIVU gives s = all ones; REMU gives s = a. Full WIDTH cycles still elapse.
- done is high for exactly one cycle per accepted op and is 0 otherwise.
- s and z hold their value between completions.
- z is always computed from the value written to s.

Test Plan:
- Reset: reset=1 for 2 cycles, then release -> s=0, z=1, busy=0, done=0.
- ADD: a=0xFFFFFFFF, b=1, op=00000 -> next cycle s=0, z=1, done=1. SUB: a=5, b=7, op=00100 -> s=0xFFFFFFFE, z=0.
- Shifts: a=0x24 (low 5 bits=4), b=0x80000000.
  - op=00011 -> s=0.
  - op=00111 -> s=0x08000000.
  - op=01111 -> s=0xF8000000.
  - op=x110 with b=0x1234 -> s=0x12340000.
- Multiply: a=0xFFFFFFFF, b=2, start at T.
  - MULLO -> busy for 32 cycles, done at T+33, s=0xFFFFFFFE.
  - MULHI on the same operands -> s=1.
  - Changing a during busy -> no effect on the result.
- Divide: a=100, b=7 -> DIVU s=14, REMU s=2. With b=0: DIVU s=0xFFFFFFFF, REMU s=100, z=0.
- Control:
  - start pulsed mid-MUL -> ignored; exactly one done pulse.
  - reset asserted at iteration 10 of DIVU -> busy=0 next cycle, no done, s=0.
  - Back-to-back start on the done cycle -> accepted.
